// File: rtl/sap1_pkg.sv
// Shared SAP-1 constants, opcode encoding and W-bus source encoding.
package sap1_pkg;

  localparam int unsigned SAP1_DATA_W = 8;
  localparam int unsigned SAP1_ADDR_W = 4;

  typedef enum logic [3:0] {
    OP_LDA = 4'b0000,
    OP_ADD = 4'b0001,
    OP_SUB = 4'b0010,
    OP_OUT = 4'b1110,
    OP_HLT = 4'b1111
  } opcode_e;

  // Winning W-bus driver after fixed-priority arbitration.
  typedef enum logic [2:0] {
    SRC_NONE = 3'd0,
    SRC_PC   = 3'd1,
    SRC_RAM  = 3'd2,
    SRC_IR   = 3'd3,
    SRC_A    = 3'd4,
    SRC_ALU  = 3'd5
  } bus_src_e;

endpackage

// File: rtl/sap1_ram.sv
// 16x8 program/data memory: combinational read port, synchronous program-load write port.
module sap1_ram #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Not reset: program contents survive a system clear.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sap1_datapath.sv
// SAP-1 datapath: PC, MAR, IR, A, B, OUT, ALU and W-bus around a sap1_ram.
// Optional bus-contention flag enabled with `define SAP1_BUS_CHECK_EN.
module sap1_datapath
  import sap1_pkg::*;
#(
  parameter int unsigned DATA_W = SAP1_DATA_W,
  parameter int unsigned ADDR_W = SAP1_ADDR_W
) (
  input  logic              CLK,
  input  logic              CLR_bar,
  input  logic              Cp,
  input  logic              Ep,
  input  logic              Ea,
  input  logic              Su,
  input  logic              Eu,
  input  logic              Lm_bar,
  input  logic              CE_bar,
  input  logic              Li_bar,
  input  logic              Ei_bar,
  input  logic              La_bar,
  input  logic              Lb_bar,
  input  logic              Lo_bar,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [3:0]        instruction_output,
  output logic [DATA_W-1:0] out_reg,
  output logic [DATA_W-1:0] w_bus,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] mar,
  output logic              bus_err
);

  logic [ADDR_W-1:0] pc_q, pc_d, mar_q, mar_d;
  logic [DATA_W-1:0] ir_q, ir_d, a_q, a_d, b_q, b_d, out_q, out_d;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] alu_res;
  bus_src_e          bus_src;

  sap1_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk_i  (CLK),
    .we_i   (prog_we),
    .waddr_i(prog_addr),
    .wdata_i(prog_data),
    .raddr_i(mar_q),
    .rdata_o(ram_rdata)
  );

  assign alu_res = Su ? (a_q - b_q) : (a_q + b_q);

  // Fixed-priority source select: PC > RAM > IR operand > A > ALU.
  always_comb begin
    bus_src = SRC_NONE;
    if (Ep)           bus_src = SRC_PC;
    else if (!CE_bar) bus_src = SRC_RAM;
    else if (!Ei_bar) bus_src = SRC_IR;
    else if (Ea)      bus_src = SRC_A;
    else if (Eu)      bus_src = SRC_ALU;
  end

  always_comb begin
    w_bus = '0;
    unique case (bus_src)
      SRC_PC:   w_bus = DATA_W'(pc_q);
      SRC_RAM:  w_bus = ram_rdata;
      SRC_IR:   w_bus = DATA_W'(ir_q[3:0]);
      SRC_A:    w_bus = a_q;
      SRC_ALU:  w_bus = alu_res;
      default:  w_bus = '0;
    endcase
  end

  always_comb begin
    pc_d  = pc_q;
    mar_d = mar_q;
    ir_d  = ir_q;
    a_d   = a_q;
    b_d   = b_q;
    out_d = out_q;
    if (Cp)      pc_d  = pc_q + ADDR_W'(1);
    if (!Lm_bar) mar_d = w_bus[ADDR_W-1:0];
    if (!Li_bar) ir_d  = w_bus;
    if (!La_bar) a_d   = w_bus;
    if (!Lb_bar) b_d   = w_bus;
    if (!Lo_bar) out_d = w_bus;
  end

  always_ff @(posedge CLK or negedge CLR_bar) begin
    if (!CLR_bar) begin
      pc_q  <= '0;
      mar_q <= '0;
      ir_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      out_q <= '0;
    end else begin
      pc_q  <= pc_d;
      mar_q <= mar_d;
      ir_q  <= ir_d;
      a_q   <= a_d;
      b_q   <= b_d;
      out_q <= out_d;
    end
  end

`ifdef SAP1_BUS_CHECK_EN
  logic [2:0] n_src;
  logic       bus_err_q, bus_err_d;

  assign n_src = 3'(Ep) + 3'(~CE_bar) + 3'(~Ei_bar) + 3'(Ea) + 3'(Eu);

  always_comb begin
    bus_err_d = bus_err_q;
    if (n_src > 3'd1) bus_err_d = 1'b1;
  end

  // Sticky until the next system clear.
  always_ff @(posedge CLK or negedge CLR_bar) begin
    if (!CLR_bar) bus_err_q <= 1'b0;
    else          bus_err_q <= bus_err_d;
  end

  assign bus_err = bus_err_q;
`else
  assign bus_err = 1'b0;
`endif

  assign instruction_output = ir_q[DATA_W-1 -: 4];
  assign out_reg            = out_q;
  assign pc                 = pc_q;
  assign mar                = mar_q;

endmodule

// File: tb/tb_sap1_datapath.sv
// Directed bench for sap1_datapath: SAP-1 program table plus ALU, PC, contention and clear sequences.
module tb_sap1_datapath;

  logic       CLK = 1'b0;
  logic       CLR_bar;
  logic       Cp, Ep, Ea, Su, Eu;
  logic       Lm_bar, CE_bar, Li_bar, Ei_bar, La_bar, Lb_bar, Lo_bar;
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;
  logic [3:0] instruction_output;
  logic [7:0] out_reg, w_bus;
  logic [3:0] pc, mar;
  logic       bus_err;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef SAP1_BUS_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  // Asserted-sense control word: {cp,ep,ea,su,eu,lm,ce,li,ei,la,lb,lo}
  typedef struct packed {
    logic cp, ep, ea, su, eu, lm, ce, li, ei, la, lb, lo;
  } ctrl_t;

  localparam ctrl_t NOP   = ctrl_t'(12'b0000_0000_0000);
  localparam ctrl_t EP_LM = ctrl_t'(12'b0100_0100_0000);
  localparam ctrl_t CP    = ctrl_t'(12'b1000_0000_0000);
  localparam ctrl_t CE_LI = ctrl_t'(12'b0000_0011_0000);
  localparam ctrl_t EI_LM = ctrl_t'(12'b0000_0100_1000);
  localparam ctrl_t CE_LA = ctrl_t'(12'b0000_0010_0100);
  localparam ctrl_t CE_LB = ctrl_t'(12'b0000_0010_0010);
  localparam ctrl_t EU_LA = ctrl_t'(12'b0000_1000_0100);
  localparam ctrl_t EA_LO = ctrl_t'(12'b0010_0000_0001);
  localparam ctrl_t EA    = ctrl_t'(12'b0010_0000_0000);
  localparam ctrl_t CE    = ctrl_t'(12'b0000_0010_0000);
  localparam ctrl_t SU_F  = ctrl_t'(12'b0001_0000_0000);
  localparam ctrl_t EP_CP = ctrl_t'(12'b1100_0000_0000);
  localparam ctrl_t EP_CE = ctrl_t'(12'b0100_0010_0000);

  typedef struct {
    ctrl_t      c;
    logic [7:0] bus;
    logic [3:0] pc, mar, instr;
    logic [7:0] out;
  } vec_t;

  vec_t vecs [21];

  sap1_datapath dut (
    .CLK(CLK), .CLR_bar(CLR_bar),
    .Cp(Cp), .Ep(Ep), .Ea(Ea), .Su(Su), .Eu(Eu),
    .Lm_bar(Lm_bar), .CE_bar(CE_bar), .Li_bar(Li_bar), .Ei_bar(Ei_bar),
    .La_bar(La_bar), .Lb_bar(Lb_bar), .Lo_bar(Lo_bar),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .instruction_output(instruction_output), .out_reg(out_reg), .w_bus(w_bus),
    .pc(pc), .mar(mar), .bus_err(bus_err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input ctrl_t c);
    Cp = c.cp; Ep = c.ep; Ea = c.ea; Su = c.su; Eu = c.eu;
    Lm_bar = ~c.lm; CE_bar = ~c.ce; Li_bar = ~c.li; Ei_bar = ~c.ei;
    La_bar = ~c.la; Lb_bar = ~c.lb; Lo_bar = ~c.lo;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic prog(input logic [3:0] a, input logic [7:0] d);
    prog_addr = a; prog_data = d; prog_we = 1'b1;
    tick();
    prog_we = 1'b0;
  endtask

  // Load A or B from scratch word RAM[0]; relies on MAR == 0.
  task automatic ld(input logic [7:0] v, input bit to_a);
    prog(4'h0, v);
    drive(to_a ? CE_LA : CE_LB);
    tick();
    drive(NOP);
  endtask

  task automatic clear_pulse();
    #2 CLR_bar = 1'b0;
    #1 CLR_bar = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{EP_LM, 8'h00, 4'h0, 4'h0, 4'h0, 8'h00};
    vecs[1]  = '{CP,    8'h00, 4'h1, 4'h0, 4'h0, 8'h00};
    vecs[2]  = '{CE_LI, 8'h09, 4'h1, 4'h0, 4'h0, 8'h00};
    vecs[3]  = '{EI_LM, 8'h09, 4'h1, 4'h9, 4'h0, 8'h00};
    vecs[4]  = '{CE_LA, 8'h10, 4'h1, 4'h9, 4'h0, 8'h00};
    vecs[5]  = '{NOP,   8'h00, 4'h1, 4'h9, 4'h0, 8'h00};
    vecs[6]  = '{EP_LM, 8'h01, 4'h1, 4'h1, 4'h0, 8'h00};
    vecs[7]  = '{CP,    8'h00, 4'h2, 4'h1, 4'h0, 8'h00};
    vecs[8]  = '{CE_LI, 8'h1A, 4'h2, 4'h1, 4'h1, 8'h00};
    vecs[9]  = '{EI_LM, 8'h0A, 4'h2, 4'hA, 4'h1, 8'h00};
    vecs[10] = '{CE_LB, 8'h14, 4'h2, 4'hA, 4'h1, 8'h00};
    vecs[11] = '{EU_LA, 8'h24, 4'h2, 4'hA, 4'h1, 8'h00};
    vecs[12] = '{EP_LM, 8'h02, 4'h2, 4'h2, 4'h1, 8'h00};
    vecs[13] = '{CP,    8'h00, 4'h3, 4'h2, 4'h1, 8'h00};
    vecs[14] = '{CE_LI, 8'hE0, 4'h3, 4'h2, 4'hE, 8'h00};
    vecs[15] = '{EA_LO, 8'h24, 4'h3, 4'h2, 4'hE, 8'h24};
    vecs[16] = '{NOP,   8'h00, 4'h3, 4'h2, 4'hE, 8'h24};
    vecs[17] = '{NOP,   8'h00, 4'h3, 4'h2, 4'hE, 8'h24};
    vecs[18] = '{EP_LM, 8'h03, 4'h3, 4'h3, 4'hE, 8'h24};
    vecs[19] = '{CP,    8'h00, 4'h4, 4'h3, 4'hE, 8'h24};
    vecs[20] = '{CE_LI, 8'hF0, 4'h4, 4'h3, 4'hF, 8'h24};

    CLR_bar = 1'b0;
    prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    drive(NOP);

    // Program loads while held in clear: RAM writes ignore CLR_bar.
    prog(4'h0, 8'h09); prog(4'h1, 8'h1A); prog(4'h2, 8'hE0);
    prog(4'h3, 8'hF0); prog(4'h9, 8'h10); prog(4'hA, 8'h14);
    chk("rst_pc",    32'(pc), 32'h0);
    chk("rst_mar",   32'(mar), 32'h0);
    chk("rst_instr", 32'(instruction_output), 32'h0);
    chk("rst_out",   32'(out_reg), 32'h0);
    chk("rst_err",   32'(bus_err), 32'h0);
    chk("rst_bus",   32'(w_bus), 32'h0);
    CLR_bar = 1'b1;

    // LDA 9 / ADD A / OUT / HLT fetch
    for (int i = 0; i < 21; i++) begin
      drive(vecs[i].c);
      #1;
      chk($sformatf("prog_bus[%0d]", i), 32'(w_bus), 32'(vecs[i].bus));
      tick();
      chk($sformatf("prog_pc[%0d]", i),    32'(pc), 32'(vecs[i].pc));
      chk($sformatf("prog_mar[%0d]", i),   32'(mar), 32'(vecs[i].mar));
      chk($sformatf("prog_instr[%0d]", i), 32'(instruction_output), 32'(vecs[i].instr));
      chk($sformatf("prog_out[%0d]", i),   32'(out_reg), 32'(vecs[i].out));
    end
    drive(NOP);
    chk("prog_no_err", 32'(bus_err), 32'h0);

    // ALU subtract and add wrap
    clear_pulse();
    ld(8'h05, 1'b1); ld(8'h07, 1'b0);
    drive(EU_LA | SU_F); #1;
    chk("sub_bus", 32'(w_bus), 32'hFE);
    tick(); drive(EA); #1;
    chk("sub_a", 32'(w_bus), 32'hFE);
    drive(NOP);
    ld(8'hFF, 1'b1); ld(8'h01, 1'b0);
    drive(EU_LA); #1;
    chk("add_bus", 32'(w_bus), 32'h00);
    tick(); drive(EA); #1;
    chk("add_a", 32'(w_bus), 32'h00);
    drive(NOP);

    // PC wrap and Ep+Cp shows pre-increment value
    clear_pulse();
    drive(CP);
    for (int i = 0; i < 15; i++) tick();
    drive(NOP);
    chk("pc_15", 32'(pc), 32'hF);
    drive(EP_CP); #1;
    chk("epcp_bus", 32'(w_bus), 32'h0F);
    tick(); drive(NOP);
    chk("pc_wrap", 32'(pc), 32'h0);

    // Write and read same RAM word in one cycle returns old data
    drive(CE);
    prog_addr = 4'h0; prog_data = 8'h55; prog_we = 1'b1; #1;
    chk("ram_old", 32'(w_bus), 32'h01);
    tick(); prog_we = 1'b0;
    chk("ram_new", 32'(w_bus), 32'h55);

    // Contention: PC wins the bus; flag is sticky when built in
    drive(CP); tick();
    drive(NOP);
    chk("pre_err", 32'(bus_err), 32'h0);
    drive(EP_CE); #1;
    chk("cont_bus", 32'(w_bus), 32'h01);
    tick(); drive(NOP);
    chk("cont_err", 32'(bus_err), 32'(EXP_ERR));
    tick();
    chk("cont_err_hold", 32'(bus_err), 32'(EXP_ERR));
    clear_pulse();
    chk("cont_err_clr", 32'(bus_err), 32'h0);

    // Asynchronous clear between edges with A=33, PC=7, OUT=33
    tick();
    ld(8'h33, 1'b1);
    drive(CP);
    for (int i = 0; i < 7; i++) tick();
    drive(EA_LO); tick();
    chk("pre_clr_pc",  32'(pc), 32'h7);
    chk("pre_clr_out", 32'(out_reg), 32'h33);
    drive(EA);
    #2 CLR_bar = 1'b0;
    #1;
    chk("clr_a",   32'(w_bus), 32'h00);
    chk("clr_pc",  32'(pc), 32'h0);
    chk("clr_out", 32'(out_reg), 32'h00);
    CLR_bar = 1'b1;
    drive(CE); #1;
    chk("clr_ram_kept", 32'(w_bus), 32'h33);
    drive(CP); tick(); drive(NOP);
    chk("clr_resume_pc", 32'(pc), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
